// File: rtl/sevenseg_capture_pkg.sv
// rtl/sevenseg_capture_pkg.sv - shared pattern constants and decode result type for sevenseg_capture
package sevenseg_capture_pkg;
  `include "sevenseg_defs.vh"

  typedef struct packed {
    logic [3:0] value;
    logic       blank;
    logic       err;
  } seg_dec_t;
endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - combinational active-low pattern to digit value decoder
// Define SEVENSEG_CAP_HEX_EN to accept the A-F patterns as valid values.
module seg_pattern_decode
  import sevenseg_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       blank,
  output logic       err
);

  always_comb begin
    value = SEG_VAL_ERR;
    blank = 1'b0;
    err   = 1'b1;
    case (pattern)
      SEG_PAT_0: begin value = 4'h0; err = 1'b0; end
      SEG_PAT_1: begin value = 4'h1; err = 1'b0; end
      SEG_PAT_2: begin value = 4'h2; err = 1'b0; end
      SEG_PAT_3: begin value = 4'h3; err = 1'b0; end
      SEG_PAT_4: begin value = 4'h4; err = 1'b0; end
      SEG_PAT_5: begin value = 4'h5; err = 1'b0; end
      SEG_PAT_6: begin value = 4'h6; err = 1'b0; end
      SEG_PAT_7: begin value = 4'h7; err = 1'b0; end
      SEG_PAT_8: begin value = 4'h8; err = 1'b0; end
      SEG_PAT_9: begin value = 4'h9; err = 1'b0; end
      SEG_PAT_BLANK: begin value = SEG_VAL_BLANK; blank = 1'b1; err = 1'b0; end
`ifdef SEVENSEG_CAP_HEX_EN
      SEG_PAT_A: begin value = 4'hA; err = 1'b0; end
      SEG_PAT_B: begin value = 4'hB; err = 1'b0; end
      SEG_PAT_C: begin value = 4'hC; err = 1'b0; end
      SEG_PAT_D: begin value = 4'hD; err = 1'b0; end
      SEG_PAT_E: begin value = 4'hE; err = 1'b0; end
      SEG_PAT_F: begin value = 4'hF; err = 1'b0; end
`else
      SEG_PAT_A, SEG_PAT_B, SEG_PAT_C, SEG_PAT_D, SEG_PAT_E, SEG_PAT_F: begin
        value = SEG_VAL_ERR;
        err   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/sevenseg_defs.vh
// rtl/sevenseg_defs.vh - active-low seven-segment pattern constants and value codes (g..a order)
`ifndef SEVENSEG_DEFS_VH
`define SEVENSEG_DEFS_VH
localparam logic [6:0] SEG_PAT_0     = 7'b1000000;
localparam logic [6:0] SEG_PAT_1     = 7'b1111001;
localparam logic [6:0] SEG_PAT_2     = 7'b0100100;
localparam logic [6:0] SEG_PAT_3     = 7'b0110000;
localparam logic [6:0] SEG_PAT_4     = 7'b0011001;
localparam logic [6:0] SEG_PAT_5     = 7'b0010010;
localparam logic [6:0] SEG_PAT_6     = 7'b0000010;
localparam logic [6:0] SEG_PAT_7     = 7'b1111000;
localparam logic [6:0] SEG_PAT_8     = 7'b0000000;
localparam logic [6:0] SEG_PAT_9     = 7'b0010000;
localparam logic [6:0] SEG_PAT_A     = 7'b0001000;
localparam logic [6:0] SEG_PAT_B     = 7'b0000011;
localparam logic [6:0] SEG_PAT_C     = 7'b1000110;
localparam logic [6:0] SEG_PAT_D     = 7'b0100001;
localparam logic [6:0] SEG_PAT_E     = 7'b0000110;
localparam logic [6:0] SEG_PAT_F     = 7'b0001110;
localparam logic [6:0] SEG_PAT_BLANK = 7'b1111111;
localparam logic [3:0] SEG_VAL_BLANK = 4'hF;
localparam logic [3:0] SEG_VAL_ERR   = 4'hF;
`endif

// File: rtl/sevenseg_capture.sv
// rtl/sevenseg_capture.sv - debounced read-back of a multiplexed active-low seven-segment bus
// Hex digit acceptance follows SEVENSEG_CAP_HEX_EN inside seg_pattern_decode.
module sevenseg_capture
  import sevenseg_capture_pkg::*;
#(
  parameter int NDIG   = 4,
  parameter int STABLE = 3,
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1,
  localparam int CNT_W = $clog2(STABLE + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_in,
  input  logic [NDIG-1:0]     an_in,
  output logic [4*NDIG-1:0]   digits,
  output logic [NDIG-1:0]     blank,
  output logic [NDIG-1:0]     err,
  output logic                update,
  output logic [IDX_W-1:0]    upd_idx
);

  logic [6:0]        seg_q;
  logic [NDIG-1:0]   an_q;
  logic [6:0]        cand_q [NDIG];
  logic [6:0]        cand_d [NDIG];
  logic [CNT_W-1:0]  cnt_q  [NDIG];
  logic [CNT_W-1:0]  cnt_d  [NDIG];
  logic [6:0]        com_q  [NDIG];
  logic [6:0]        com_d  [NDIG];
  logic [4*NDIG-1:0] digits_q, digits_d;
  logic [NDIG-1:0]   blank_q, blank_d;
  logic [NDIG-1:0]   err_q, err_d;
  logic              update_q, update_d;
  logic [IDX_W-1:0]  upd_idx_q, upd_idx_d;
  logic              valid;
  logic [CNT_W-1:0]  new_cnt;
  seg_dec_t          dec;

  seg_pattern_decode u_decode (
    .pattern (seg_q),
    .value   (dec.value),
    .blank   (dec.blank),
    .err     (dec.err)
  );

  // A sample is only meaningful when exactly one digit enable is active.
  always_comb begin
    int n_act;
    n_act = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (!an_q[i]) n_act++;
    end
    valid = (n_act == 1);
  end

  always_comb begin
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    com_d     = com_q;
    digits_d  = digits_q;
    blank_d   = blank_q;
    err_d     = err_q;
    update_d  = 1'b0;
    upd_idx_d = upd_idx_q;
    new_cnt   = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (valid && !an_q[i]) begin
        if (seg_q == cand_q[i]) begin
          new_cnt = (cnt_q[i] == CNT_W'(STABLE)) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
        end else begin
          cand_d[i] = seg_q;
          new_cnt   = CNT_W'(1);
        end
        cnt_d[i] = new_cnt;
        if (new_cnt == CNT_W'(STABLE) && seg_q != com_q[i]) begin
          com_d[i]          = seg_q;
          digits_d[4*i +: 4] = dec.value;
          blank_d[i]        = dec.blank;
          err_d[i]          = dec.err;
          update_d          = 1'b1;
          upd_idx_d         = IDX_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q     <= '1;
      an_q      <= '1;
      for (int i = 0; i < NDIG; i++) begin
        cand_q[i] <= SEG_PAT_BLANK;
        cnt_q[i]  <= '0;
        com_q[i]  <= SEG_PAT_BLANK;
      end
      digits_q  <= {NDIG{SEG_VAL_BLANK}};
      blank_q   <= '1;
      err_q     <= '0;
      update_q  <= 1'b0;
      upd_idx_q <= '0;
    end else begin
      seg_q     <= seg_in;
      an_q      <= an_in;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      com_q     <= com_d;
      digits_q  <= digits_d;
      blank_q   <= blank_d;
      err_q     <= err_d;
      update_q  <= update_d;
      upd_idx_q <= upd_idx_d;
    end
  end

  assign digits  = digits_q;
  assign blank   = blank_q;
  assign err     = err_q;
  assign update  = update_q;
  assign upd_idx = upd_idx_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb/tb_sevenseg_capture.sv - directed self-checking bench for sevenseg_capture
module tb_sevenseg_capture;

  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] PA = 7'b0001000;
  localparam logic [6:0] PBL = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  err;
  logic        update;
  logic [1:0]  upd_idx;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  int idx_log [$];

  always #5 clk = ~clk;

  sevenseg_capture #(.NDIG(4), .STABLE(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .seg_in  (seg_in),
    .an_in   (an_in),
    .digits  (digits),
    .blank   (blank),
    .err     (err),
    .update  (update),
    .upd_idx (upd_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (update === 1'b1) begin
        pulses++;
        idx_log.push_back(int'(upd_idx));
      end
    end
  endtask

  task automatic clear_log();
    pulses = 0;
    idx_log.delete();
  endtask

  initial begin
    logic [6:0] scan_pat [4];
    logic [6:0] glitch [6];
    scan_pat[0] = P1; scan_pat[1] = P2; scan_pat[2] = P3; scan_pat[3] = P4;
    glitch[0] = P8; glitch[1] = P8; glitch[2] = P0;
    glitch[3] = P8; glitch[4] = P8; glitch[5] = P8;

    rst_n = 1'b0; an_in = 4'hF; seg_in = PBL;
    tick(2);
    rst_n = 1'b1;
    check("rst_digits", digits, 16'hFFFF);
    check("rst_blank", blank, 4'hF);
    check("rst_err", err, 4'h0);
    check("rst_update", update, 1'b0);
    check("rst_upd_idx", upd_idx, 2'd0);
    clear_log();
    tick(6);
    check("idle_pulses", pulses, 0);

    // Hold digit 0 on "2": captured at the first edge, committed three edges later.
    clear_log();
    an_in = 4'b1110; seg_in = P2;
    tick(3);
    check("hold_early", pulses, 0);
    tick(1);
    check("hold_pulse", pulses, 1);
    check("hold_idx", upd_idx, 2'd0);
    check("hold_digit", digits[3:0], 4'h2);
    tick(8);
    check("hold_no_repeat", pulses, 1);

    clear_log();
    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < 4; d++) begin
        an_in = ~(4'b0001 << d);
        seg_in = scan_pat[d];
        tick(1);
      end
    end
    an_in = 4'hF; seg_in = PBL;
    tick(3);
    check("scan_pulses", pulses, 4);
    for (int d = 0; d < 4; d++)
      check($sformatf("scan_idx%0d", d), (idx_log.size() > d) ? idx_log[d] : -1, d);
    check("scan_digits", digits, 16'h4321);
    check("scan_blank", blank, 4'h0);
    check("scan_err", err, 4'h0);

    clear_log();
    an_in = 4'b1101;
    for (int k = 0; k < 6; k++) begin
      seg_in = glitch[k];
      tick(1);
      if (k == 4) check("glitch_early", pulses, 0);
    end
    an_in = 4'hF; seg_in = PBL;
    tick(3);
    check("glitch_pulses", pulses, 1);
    check("glitch_idx", (idx_log.size() > 0) ? idx_log[0] : -1, 1);
    check("glitch_digits", digits, 16'h4381);

    clear_log();
    an_in = 4'b1100; seg_in = PA;
    tick(10);
    an_in = 4'hF; seg_in = PBL;
    tick(3);
    check("multi_pulses", pulses, 0);
    check("multi_digits", digits, 16'h4381);
    check("multi_err", err, 4'h0);

    clear_log();
    an_in = 4'b1011; seg_in = PA;
    tick(3);
    an_in = 4'hF; seg_in = PBL;
    tick(3);
    check("hexa_pulses", pulses, 1);
`ifdef SEVENSEG_CAP_HEX_EN
    check("hexa_digits", digits, 16'h4A81);
    check("hexa_err", err, 4'h0);
`else
    check("hexa_digits", digits, 16'h4F81);
    check("hexa_err", err, 4'h4);
`endif

    clear_log();
    an_in = 4'b0111; seg_in = PBL;
    tick(3);
    an_in = 4'hF;
    tick(3);
    check("blank_pulses", pulses, 1);
    check("blank_bits", blank, 4'h8);
    check("blank_digit", digits[15:12], 4'hF);

    // Two samples of "5" on digit 0 (cnt=2), then a single reset cycle.
    clear_log();
    an_in = 4'b1110; seg_in = P5;
    tick(3);
    check("pre_rst_pulses", pulses, 0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("mid_rst_update", update, 1'b0);
    check("mid_rst_digits", digits, 16'hFFFF);
    check("mid_rst_blank", blank, 4'hF);
    check("mid_rst_err", err, 4'h0);
    clear_log();
    tick(3);
    check("post_rst_early", pulses, 0);
    tick(1);
    check("post_rst_pulse", pulses, 1);
    check("post_rst_digits", digits, 16'hFFF5);
    check("post_rst_blank", blank, 4'hE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
# sevenseg_capture

Read-back monitor for the multiplexed, active-low seven-segment display bus driven by the processor's display path. It samples segment and digit-enable lines each clock and decodes each digit's segment pattern back to a 4-bit value. A pattern is committed only after it has been seen STABLE consecutive times, and each commit is reported with a one-cycle update pulse. It sits beside the display driver and gives the debug/self-check logic the digits the user actually sees.

## Interface
- NDIG, 4: number of multiplexed digits (≥1).
- STABLE, 3: consecutive identical samples per digit required to commit (≥1).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- seg_in  in  7  segment lines, active-low; bit0=a … bit6=g.
- an_in  in  NDIG  digit enables, active-low.
- digits  out  4*NDIG  committed value per digit; digit i at [4i+3:4i].
- blank  out  NDIG  digit i committed the all-off pattern.
- err  out  NDIG  digit i committed an undecodable pattern.
- update  out  1  one-cycle pulse: a digit committed this cycle.
- upd_idx  out  clog2(NDIG) (min 1)  index of the digit committed with update.

## Operation
- Input stage: seg_in and an_in registered into seg_q/an_q every cycle. Reset loads all ones (idle).
- Valid sample: exactly one bit of an_q is 0. Zero or multiple active bits mean no sample, and no per-digit state changes.
- Per-digit state: cand[i] (7b), cnt[i] (saturating at STABLE), com[i] (committed pattern, 7b).
- On a valid sample for digit i:
  - If seg_q==cand[i], cnt[i] increments, saturating at STABLE.
  - Otherwise cand[i]=seg_q and cnt[i]=1.
- Commit: in the cycle where cnt[i]'s new value equals STABLE and seg_q≠com[i]:
  - com[i]=seg_q.
  - digits/blank/err for digit i are updated.
  - update=1 and upd_idx=i.
- Saturated, unchanged patterns produce no further pulses.
- Samples of other digits do not disturb digit i's state.
- Decode (active-low, g..a):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000.
  - 1111111 decodes to value 4'hF, blank=1, err=0.
  - Any other pattern decodes to value 4'hF, blank=0, err=1.
  - A decimal pattern decodes to its value, blank=0, err=0.
- STABLE=1: every changed pattern commits on its first sample.

## Timing
- Reset values:
  - digits: all 4'hF.
  - blank: all 1.
  - err: 0.
  - update: 0.
  - upd_idx: 0.
  - cand and com: 7'h7F.
  - cnt: 0.
  - seg_q and an_q: all 1.
- Latency: a digit held active with a constant pattern captured at edges E…E+STABLE-1 commits at edge E+STABLE. Outputs and the update pulse are visible in the following cycle.
- update is high for exactly one cycle per commit. Commits are at most one per cycle because a valid sample is one-hot.
- Reset asserted mid-count discards all partial counts and committed values. update is 0 in the cycle after the reset edge.

## Configuration
- SEVENSEG_CAP_HEX_EN defined: patterns A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110 decode to 4'hA–4'hF with err=0.
- Without the macro, these patterns give err=1.
- Blank and error handling are otherwise unchanged.

## Structure
- Shared header sevenseg_defs.vh holds:
  - the pattern constants for 0–9, A–F and blank;
  - the BLANK and ERR value codes.
- The display driver uses the same header.
- Sub-module seg_pattern_decode is combinational: 7-bit pattern in; value, blank and err out. The macro is honoured inside it. Instantiate it once on seg_q.

## Test plan
- Reset, then idle inputs: digits=16'hFFFF, blank=4'hF, err=0, update never asserts.
- Hold an_in=4'b1110 with seg_in=7'b0100100 ("2"), STABLE=3: one update pulse at upd_idx=0 three edges after the first capture; digits[3:0]=2. Holding further produces no further pulses.
- Scan 4 digits round-robin with patterns "1","2","3","4", one cycle each: after each digit's third sample, four pulses follow with upd_idx 0..3 in order; digits=16'h4321.
- Glitch: digit 1 shows "8", "8", "0", "8", "8", "8": commit occurs only after the last three "8"s; no commit of "0".
- an_in=4'b1100 (two active) with a new pattern for 10 cycles: no state change and no update. Pattern 7'b0001000: err[i]=1 without the macro; value 4'hA, err=0 with SEVENSEG_CAP_HEX_EN.
- Assert rst_n=0 for one cycle when cnt=2: all outputs return to reset values; the next commit again requires 3 fresh samples.
